// File: rtl/sha256_compress_round_iter.sv
// Iterative SHA-256 compression: one round per accepted W_t beat, feed-forward add after round 63.
// state | meaning
// IDLE  | waiting for start; w_valid ignored
// RUN   | one round per w_valid beat, stalls hold state
// FINAL | one cycle: digest register loads, digest_valid follows
module sha256_compress_round_iter #(
  parameter logic FEED_FORWARD = 1'b1,
  parameter logic HOLD_DIGEST  = 1'b1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [255:0] h_in,
  input  logic         w_valid,
  input  logic [31:0]  w_in,
  output logic         w_ready,
  output logic         busy,
  output logic [5:0]   round_cnt,
  output logic         digest_valid,
  output logic [255:0] digest
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINAL} state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t       state, state_nxt;
  logic [255:0] h_init;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic         beat;
  logic [31:0]  big_s0, big_s1, ch, maj, t1, t2;
  logic [255:0] work, digest_nxt;

  assign beat    = (state == ST_RUN) && w_valid;
  assign w_ready = (state == ST_RUN);
  assign busy    = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (beat && (round_cnt == 6'd63)) state_nxt = ST_FINAL;
      ST_FINAL: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    big_s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
    big_s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
    ch     = (e & f) ^ (~e & g);
    maj    = (a & b) ^ (a & c) ^ (b & c);
    t1     = h + big_s1 + ch + K_ROM[round_cnt] + w_in;
    t2     = big_s0 + maj;
  end

  // word 0 (a / H0) sits in the top 32 bits, matching h_in and digest order
  always_comb begin
    work       = {a, b, c, d, e, f, g, h};
    digest_nxt = work;
    if (FEED_FORWARD) begin
      for (int i = 0; i < 8; i++) begin
        digest_nxt[i*32 +: 32] = h_init[i*32 +: 32] + work[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      round_cnt    <= 6'd0;
      h_init       <= '0;
      {a, b, c, d} <= '0;
      {e, f, g, h} <= '0;
      digest_valid <= 1'b0;
      digest       <= '0;
    end else begin
      digest_valid <= (state == ST_FINAL);
      if ((state == ST_IDLE) && start) begin
        h_init                 <= h_in;
        {a, b, c, d, e, f, g, h} <= h_in;
        round_cnt              <= 6'd0;
      end else if (beat) begin
        h         <= g;
        g         <= f;
        f         <= e;
        e         <= d + t1;
        d         <= c;
        c         <= b;
        b         <= a;
        a         <= t1 + t2;
        round_cnt <= round_cnt + 6'd1;
      end
      if (state == ST_FINAL) begin
        digest <= digest_nxt;
      end else if (!HOLD_DIGEST && digest_valid) begin
        digest <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sha256_compress_round_iter.sv
// Directed bench: "abc" single-block compression on a feed-forward/holding instance and a raw/clearing instance.
module tb_sha256_compress_round_iter;

  localparam logic [255:0] H_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic [255:0] h_in = '0;
  logic         w_valid = 1'b0;
  logic [31:0]  w_in = '0;

  logic         w_ready, busy, digest_valid;
  logic [5:0]   round_cnt;
  logic [255:0] digest;
  logic         w_ready_r, busy_r, digest_valid_r;
  logic [5:0]   round_cnt_r;
  logic [255:0] digest_r;

  logic [31:0]  w_sched [64];
  logic [255:0] exp_raw;
  int           total = 0;
  int           bad = 0;

  always #5 CLK = ~CLK;

  sha256_compress_round_iter dut (
    .CLK(CLK), .RST(RST), .start(start), .h_in(h_in), .w_valid(w_valid), .w_in(w_in),
    .w_ready(w_ready), .busy(busy), .round_cnt(round_cnt),
    .digest_valid(digest_valid), .digest(digest)
  );

  sha256_compress_round_iter #(.FEED_FORWARD(1'b0), .HOLD_DIGEST(1'b0)) dut_raw (
    .CLK(CLK), .RST(RST), .start(start), .h_in(h_in), .w_valid(w_valid), .w_in(w_in),
    .w_ready(w_ready_r), .busy(busy_r), .round_cnt(round_cnt_r),
    .digest_valid(digest_valid_r), .digest(digest_r)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_w_ready"}, {255'd0, w_ready}, 256'd0);
    chk({tag, "_busy"}, {255'd0, busy}, 256'd0);
    chk({tag, "_round_cnt"}, {250'd0, round_cnt}, 256'd0);
    chk({tag, "_dv"}, {255'd0, digest_valid}, 256'd0);
    chk({tag, "_digest"}, digest, 256'd0);
    chk({tag, "_busy_raw"}, {255'd0, busy_r}, 256'd0);
    chk({tag, "_digest_raw"}, digest_r, 256'd0);
  endtask

  // Cycle 0 is the cycle start is presented (or was already presented by the caller when pre_started).
  task automatic run_abc(input bit do_stall, input int glitch_at, input int rst_at,
                         input bit pre_started, input bit chain, input bit mid_hold_chk);
    int cyc;
    bit seen;
    h_in = H_INIT;
    if (!pre_started) begin
      start   = 1'b1;
      w_valid = 1'b0;
    end
    cyc = 0;
    tick(); cyc++;
    start = 1'b0;
    chk("busy_after_start", {255'd0, busy}, 256'd1);
    for (int k = 0; k < 64; k++) begin
      if (k == rst_at) begin
        RST = 1'b1; w_valid = 1'b1; w_in = w_sched[k];
        tick();
        RST = 1'b0; w_valid = 1'b0;
        chk_reset_state("mid_run_reset");
        for (int j = 0; j < 70; j++) begin
          tick();
          if (digest_valid || busy) begin
            chk("no_dv_after_reset", {254'd0, digest_valid, busy}, 256'd0);
            break;
          end
        end
        return;
      end
      w_valid = 1'b1;
      w_in    = w_sched[k];
      start   = (k == glitch_at);
      chk("rc_beat", {250'd0, round_cnt}, 256'(k));
      chk("w_ready_run", {255'd0, w_ready}, 256'd1);
      if (mid_hold_chk && k == 10) begin
        chk("hold_mid_run2", digest, ABC_DIGEST);
        chk("clear_mid_run2_raw", digest_r, 256'd0);
      end
      tick(); cyc++;
      start = 1'b0;
      if (do_stall && (k == 0 || k == 31 || k == 62)) begin
        w_valid = 1'b0;
        w_in    = 32'hdeadbeef;
        for (int j = 0; j < 3; j++) begin
          tick(); cyc++;
          chk("rc_stall", {250'd0, round_cnt}, 256'(k + 1));
        end
      end
    end
    w_valid = 1'b1;
    w_in    = 32'h0badf00d;
    chk("final_w_ready", {255'd0, w_ready}, 256'd0);
    chk("final_busy", {255'd0, busy}, 256'd1);
    chk("final_dv", {255'd0, digest_valid}, 256'd0);
    chk("final_rc_wrap", {250'd0, round_cnt}, 256'd0);
    seen = 1'b0;
    for (int j = 0; j < 4 && !seen; j++) begin
      tick(); cyc++;
      seen = digest_valid;
    end
    w_valid = 1'b0;
    chk("dv_seen", {255'd0, seen}, 256'd1);
    chk("dv_cycle", 256'(cyc), do_stall ? 256'd75 : 256'd66);
    chk("dv_raw", {255'd0, digest_valid_r}, 256'd1);
    chk("digest_ff", digest, ABC_DIGEST);
    chk("digest_raw", digest_r, exp_raw);
    chk("dv_cycle_busy", {255'd0, busy}, 256'd0);
    if (chain) begin
      start = 1'b1;
      return;
    end
    tick();
    chk("dv_pulse", {255'd0, digest_valid}, 256'd0);
    chk("digest_hold", digest, ABC_DIGEST);
    chk("digest_raw_clear", digest_r, 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    w_sched[0] = 32'h61626380;
    for (int t = 1; t < 15; t++) w_sched[t] = 32'h0;
    w_sched[15] = 32'h00000018;
    for (int t = 16; t < 64; t++) begin
      w_sched[t] = (rotr(w_sched[t-2], 17) ^ rotr(w_sched[t-2], 19) ^ (w_sched[t-2] >> 10))
                 + w_sched[t-7]
                 + (rotr(w_sched[t-15], 7) ^ rotr(w_sched[t-15], 18) ^ (w_sched[t-15] >> 3))
                 + w_sched[t-16];
    end
    for (int i = 0; i < 8; i++) begin
      exp_raw[i*32 +: 32] = ABC_DIGEST[i*32 +: 32] - H_INIT[i*32 +: 32];
    end
    chk("raw_top_word", {224'd0, exp_raw[255:224]}, 256'h506e3058);

    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    chk_reset_state("reset");

    w_valid = 1'b1; w_in = 32'h12345678;
    tick();
    chk("idle_w_ready", {255'd0, w_ready}, 256'd0);
    chk("idle_busy", {255'd0, busy}, 256'd0);
    chk("idle_rc", {250'd0, round_cnt}, 256'd0);
    w_valid = 1'b0;
    tick();

    run_abc(1'b0, -1, -1, 1'b0, 1'b0, 1'b0);
    tick();
    run_abc(1'b1, -1, -1, 1'b0, 1'b0, 1'b0);
    tick();
    run_abc(1'b0, 20, -1, 1'b0, 1'b0, 1'b0);
    tick();
    run_abc(1'b0, -1, 40, 1'b0, 1'b0, 1'b0);
    tick();
    run_abc(1'b0, -1, -1, 1'b0, 1'b0, 1'b0);
    tick();
    run_abc(1'b0, -1, -1, 1'b0, 1'b1, 1'b0);
    run_abc(1'b0, -1, -1, 1'b1, 1'b0, 1'b1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
